// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR pattern source with wrap tick, period measurement and lockup flag.
// Define LFSR_PERIOD_CHECK_EN to flag wraps whose period is not 2^WIDTH-1 on period_err.
module lfsr_gen #(
  parameter int WIDTH = 14,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(14'h2803),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(14'h0001)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             step_en,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             msb_out,
  output logic             max_tick,
  output logic             running,
  output logic [WIDTH-1:0] period_out,
  output logic             stuck_err,
  output logic             period_err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [WIDTH-1:0] lfsr_q, seed_q, step_cnt, nxt, ld_seed;
  assign nxt = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign ld_seed = seed_in == '0 ? DEFAULT_SEED : seed_in;
  assign lfsr_out = lfsr_q;
  assign msb_out = lfsr_q[WIDTH-1];
  assign running = state == RUN;
`ifndef LFSR_PERIOD_CHECK_EN
  assign period_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      lfsr_q <= DEFAULT_SEED;
      seed_q <= DEFAULT_SEED;
      step_cnt <= '0;
      max_tick <= 1'b0;
      period_out <= '0;
      stuck_err <= 1'b0;
`ifdef LFSR_PERIOD_CHECK_EN
      period_err <= 1'b0;
`endif
    end else begin
      max_tick <= 1'b0;
      if (state == IDLE) begin
        if (seed_load) begin
          seed_q <= ld_seed;
          lfsr_q <= ld_seed;
        end
        if (start) begin
          state <= RUN;
          step_cnt <= '0;
          stuck_err <= 1'b0;
`ifdef LFSR_PERIOD_CHECK_EN
          period_err <= 1'b0;
`endif
        end
      end else begin
        if (lfsr_q == '0) stuck_err <= 1'b1;
        if (stop) state <= IDLE;
        else if (step_en) begin
          lfsr_q <= nxt;
          // wrap: the shift lands back on the seed, so one full period has elapsed
          if (nxt == seed_q) begin
            max_tick <= 1'b1;
            period_out <= step_cnt + WIDTH'(1);
            step_cnt <= '0;
`ifdef LFSR_PERIOD_CHECK_EN
            if (step_cnt + WIDTH'(1) != {WIDTH{1'b1}}) period_err <= 1'b1;
`endif
          end else step_cnt <= step_cnt + WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed vector bench for lfsr_gen across default, 4-bit maximal, short-period and zero-tap builds.
module tb_lfsr_gen;
  logic clk = 1'b0, reset_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, seed_load = 1'b0, step_en = 1'b0;
  logic [13:0] seed_in = '0;
  logic [3:0] a_lfsr, c_lfsr, e_lfsr, a_per, c_per, e_per;
  logic a_msb, a_tick, a_run, a_stuck, a_perr;
  logic c_msb, c_tick, c_run, c_stuck, c_perr;
  logic e_msb, e_tick, e_run, e_stuck, e_perr;
  logic [13:0] d_lfsr, d_per;
  logic d_msb, d_tick, d_run, d_stuck, d_perr;
  int ncmp = 0, nerr = 0;
  always #5 clk = ~clk;
  lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .DEFAULT_SEED(4'h1)) u_a (.clk(clk), .reset_n(reset_n), .start(start),
    .stop(stop), .seed_load(seed_load), .seed_in(seed_in[3:0]), .step_en(step_en), .lfsr_out(a_lfsr),
    .msb_out(a_msb), .max_tick(a_tick), .running(a_run), .period_out(a_per), .stuck_err(a_stuck), .period_err(a_perr));
  lfsr_gen #(.WIDTH(4), .TAPS(4'h8), .DEFAULT_SEED(4'h1)) u_c (.clk(clk), .reset_n(reset_n), .start(start),
    .stop(stop), .seed_load(seed_load), .seed_in(seed_in[3:0]), .step_en(step_en), .lfsr_out(c_lfsr),
    .msb_out(c_msb), .max_tick(c_tick), .running(c_run), .period_out(c_per), .stuck_err(c_stuck), .period_err(c_perr));
  lfsr_gen #(.WIDTH(4), .TAPS(4'h0), .DEFAULT_SEED(4'h1)) u_e (.clk(clk), .reset_n(reset_n), .start(start),
    .stop(stop), .seed_load(seed_load), .seed_in(seed_in[3:0]), .step_en(step_en), .lfsr_out(e_lfsr),
    .msb_out(e_msb), .max_tick(e_tick), .running(e_run), .period_out(e_per), .stuck_err(e_stuck), .period_err(e_perr));
  lfsr_gen u_d (.clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .seed_load(seed_load),
    .seed_in(seed_in), .step_en(step_en), .lfsr_out(d_lfsr), .msb_out(d_msb), .max_tick(d_tick),
    .running(d_run), .period_out(d_per), .stuck_err(d_stuck), .period_err(d_perr));
  typedef struct {
    bit st, sp, ld;
    logic [3:0] sd;
    bit en;
    logic [3:0] lf;
    bit tk, rn;
  } vec_t;
  vec_t v[$];
  function automatic void add(bit st, bit sp, bit ld, logic [3:0] sd, bit en, logic [3:0] lf, bit tk, bit rn);
    v.push_back('{st, sp, ld, sd, en, lf, tk, rn});
  endfunction
  task automatic chk(string n, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic drive(bit st, bit sp, bit ld, logic [13:0] sd, bit en);
    start = st; stop = sp; seed_load = ld; seed_in = sd; step_en = en;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
  endtask
  initial begin
    logic [3:0] s1[15] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [3:0] s2[4] = '{4'h2, 4'h4, 4'h8, 4'h1};
    int ticks;
    bit exp_perr;
`ifdef LFSR_PERIOD_CHECK_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    #12 reset_n = 1'b1;
    chk("rst_lfsr", int'(a_lfsr), 1);
    chk("rst_run", int'(a_run), 0);
    chk("rst_per", int'(a_per), 0);
    chk("rst_stuck", int'(a_stuck), 0);
    chk("rst_perr", int'(a_perr), 0);
    chk("rst_dlfsr", int'(d_lfsr), 1);
    // full 4-bit period, then held state through stop/seed_load and a second partial period
    add(1, 0, 1, 4'h1, 0, 4'h1, 0, 1);
    for (int i = 0; i < 15; i++) add(0, 0, 0, 0, 1, s1[i], i == 14, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, s1[i], 0, 1);
    add(0, 0, 1, 4'h5, 0, 4'hD, 0, 1);
    add(1, 1, 0, 0, 1, 4'hD, 0, 0);
    add(1, 0, 0, 0, 0, 4'hD, 0, 1);
    for (int i = 5; i < 15; i++) add(0, 0, 0, 0, 1, s1[i], i == 14, 1);
    foreach (v[k]) begin
      drive(v[k].st, v[k].sp, v[k].ld, {10'd0, v[k].sd}, v[k].en);
      cyc;
      chk($sformatf("vec%0d_lfsr", k), int'(a_lfsr), int'(v[k].lf));
      chk($sformatf("vec%0d_msb", k), int'(a_msb), int'(v[k].lf[3]));
      chk($sformatf("vec%0d_tick", k), int'(a_tick), int'(v[k].tk));
      chk($sformatf("vec%0d_run", k), int'(a_run), int'(v[k].rn));
      if (k == 15) chk("per15", int'(a_per), 15);
    end
    chk("per_restart", int'(a_per), 10);
    // step_en toggling: 15 shifts spread over 30 cycles
    do_reset;
    drive(1, 0, 1, 14'd1, 0);
    cyc;
    for (int i = 0; i < 30; i++) begin
      drive(0, 0, 0, 0, i % 2 == 0);
      cyc;
      chk($sformatf("tog%0d_tick", i), int'(a_tick), int'(i == 28));
    end
    chk("tog_per", int'(a_per), 15);
    chk("tog_lfsr", int'(a_lfsr), 1);
    // asynchronous reset in the middle of RUN
    drive(0, 0, 0, 0, 1);
    cyc;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_lfsr", int'(a_lfsr), 1);
    chk("arst_run", int'(a_run), 0);
    chk("arst_tick", int'(a_tick), 0);
    chk("arst_per", int'(a_per), 0);
    chk("arst_dlfsr", int'(d_lfsr), 1);
    #1 reset_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    // full default-width period with a zero seed replaced by the default seed
    drive(1, 0, 0, 0, 0);
    cyc;
    drive(0, 0, 0, 0, 1);
    repeat (3) cyc;
    drive(0, 1, 0, 0, 0);
    cyc;
    drive(1, 0, 1, 14'd0, 0);
    cyc;
    chk("zseed_lfsr", int'(d_lfsr), 1);
    ticks = 0;
    drive(0, 0, 0, 0, 1);
    for (int i = 1; i <= 16383; i++) begin
      cyc;
      if (d_tick) begin
        ticks++;
        chk("big_tick_pos", i, 16383);
      end
    end
    chk("big_ticks", ticks, 1);
    chk("big_per", int'(d_per), 16383);
    chk("big_lfsr", int'(d_lfsr), 1);
    chk("big_stuck", int'(d_stuck), 0);
    // short period (rotate) and zero-tap lockup
    do_reset;
    drive(1, 0, 1, 14'd1, 0);
    cyc;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      cyc;
      chk($sformatf("short%0d_lfsr", i), int'(c_lfsr), int'(s2[i]));
      chk($sformatf("short%0d_tick", i), int'(c_tick), int'(i == 3));
    end
    chk("short_per", int'(c_per), 4);
    chk("short_perr", int'(c_perr), int'(exp_perr));
    chk("lock_lfsr", int'(e_lfsr), 0);
    chk("lock_stuck_early", int'(e_stuck), 0);
    cyc;
    chk("lock_stuck", int'(e_stuck), 1);
    chk("lock_tick", int'(e_tick), 0);
    drive(0, 1, 0, 0, 0);
    cyc;
    chk("lock_hold", int'(e_stuck), 1);
    drive(1, 0, 1, 14'd1, 0);
    cyc;
    chk("recover_lfsr", int'(e_lfsr), 1);
    chk("recover_stuck", int'(e_stuck), 0);
    chk("recover_run", int'(e_run), 1);
    chk("recover_perr", int'(c_perr), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
